// File: rtl/mem_arb_pkg.sv
// Shared types and the round-robin pick used by the instruction/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic {
        SRC_INSTR = 1'b0,
        SRC_DATA  = 1'b1
    } src_e;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'b00,
        ARB_HOLD_I = 2'b01,
        ARB_HOLD_D = 2'b10
    } arb_state_e;

    localparam int unsigned MAX_OUTSTANDING_LIMIT = 4;

    // On a tie the source that did not win the last handshake goes first; with no request DATA is picked
    // so that an idle port mirrors the (all-zero) data payload.
    function automatic src_e rr_pick(input logic i_instr_req, input logic i_data_req, input src_e i_last);
        src_e v_pick;
        if (i_instr_req && i_data_req) begin
            v_pick = (i_last == SRC_DATA) ? SRC_INSTR : SRC_DATA;
        end else if (i_instr_req) begin
            v_pick = SRC_INSTR;
        end else begin
            v_pick = SRC_DATA;
        end
        return v_pick;
    endfunction

endpackage

// File: rtl/mem_arb_id_fifo.sv
// Small circular FIFO remembering which requester owns each outstanding memory transaction.
module mem_arb_id_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] i_ptr);
        logic [PTR_W-1:0] v_nxt;
        if (i_ptr == PTR_W'(DEPTH - 1)) begin
            v_nxt = {PTR_W{1'b0}};
        end else begin
            v_nxt = i_ptr + PTR_W'(1);
        end
        return v_nxt;
    endfunction

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == {CNT_W{1'b0}});
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_rd_ptr];

    // Storage, pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter_chk.sv
// Protocol checks for the arbiter: held requests must not drop, responses need an outstanding owner.
module mem_port_arbiter_chk
    import mem_arb_pkg::*;
(
    input logic       i_clk,
    input logic       i_rst_n,
    input arb_state_e i_state,
    input logic       i_instr_req,
    input logic       i_data_req,
    input logic       i_rvalid,
    input logic       i_fifo_empty
);

    a_hold_instr: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (i_state == ARB_HOLD_I) |-> i_instr_req)
        else $error("instr request dropped while waiting for grant");

    a_hold_data: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (i_state == ARB_HOLD_D) |-> i_data_req)
        else $error("data request dropped while waiting for grant");

    a_rvalid_owner: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        i_rvalid |-> !i_fifo_empty)
        else $error("memory response with no outstanding transaction");

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one OBI-style memory port between instruction fetch and load/store,
// routing in-order responses back to the issuing requester.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter bit          ASSERT_EN       = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    instr_req_i,
    input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
    output logic                    instr_gnt_o,
    output logic                    instr_rvalid_o,
    output logic [DATA_WIDTH-1:0]   instr_rdata_o,
    input  logic                    data_req_i,
    input  logic                    data_we_i,
    input  logic [DATA_WIDTH/8-1:0] data_be_i,
    input  logic [ADDR_WIDTH-1:0]   data_addr_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    output logic                    data_gnt_o,
    output logic                    data_rvalid_o,
    output logic [DATA_WIDTH-1:0]   data_rdata_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

    localparam int unsigned BE_W = DATA_WIDTH / 8;

    arb_state_e r_state;
    arb_state_e w_state_nxt;
    src_e       r_last_grant;
    src_e       w_sel;
    src_e       w_head_src;
    logic [0:0] w_head;
    logic       w_fifo_full;
    logic       w_fifo_empty;
    logic       w_handshake;

    // A source left waiting for a grant keeps the port; otherwise pick round-robin.
    always_comb begin
        w_sel = SRC_DATA;
        case (r_state)
            ARB_HOLD_I: w_sel = SRC_INSTR;
            ARB_HOLD_D: w_sel = SRC_DATA;
            default:    w_sel = rr_pick(instr_req_i, data_req_i, r_last_grant);
        endcase
    end

    assign mem_req_o   = ((w_sel == SRC_INSTR) ? instr_req_i : data_req_i) && !w_fifo_full;
    assign w_handshake = mem_req_o && mem_gnt_i;
    assign instr_gnt_o = w_handshake && (w_sel == SRC_INSTR);
    assign data_gnt_o  = w_handshake && (w_sel == SRC_DATA);

    // Payload mux: fetches are always full-word reads.
    always_comb begin
        mem_we_o    = 1'b0;
        mem_be_o    = {BE_W{1'b0}};
        mem_addr_o  = {ADDR_WIDTH{1'b0}};
        mem_wdata_o = {DATA_WIDTH{1'b0}};
        if (w_sel == SRC_INSTR) begin
            mem_be_o   = {BE_W{1'b1}};
            mem_addr_o = instr_addr_i;
        end else begin
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_addr_o  = data_addr_i;
            mem_wdata_o = data_wdata_i;
        end
    end

    // An issued but ungranted request pins the selection; a grant or a dropped request releases it.
    always_comb begin
        w_state_nxt = ARB_IDLE;
        if (mem_req_o && !mem_gnt_i) begin
            w_state_nxt = (w_sel == SRC_INSTR) ? ARB_HOLD_I : ARB_HOLD_D;
        end else begin
            w_state_nxt = ARB_IDLE;
        end
    end

    // Arbitration state and round-robin history.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= ARB_IDLE;
            r_last_grant <= SRC_DATA;
        end else begin
            r_state <= w_state_nxt;
            if (w_handshake) begin
                r_last_grant <= w_sel;
            end
        end
    end

    mem_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (1)
    ) u_id_fifo (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_push  (w_handshake),
        .i_data  (w_sel),
        .i_pop   (mem_rvalid_i),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_head  (w_head)
    );

    assign w_head_src     = src_e'(w_head);
    assign instr_rvalid_o = mem_rvalid_i && !w_fifo_empty && (w_head_src == SRC_INSTR);
    assign data_rvalid_o  = mem_rvalid_i && !w_fifo_empty && (w_head_src == SRC_DATA);
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;

    if (ASSERT_EN) begin : g_chk
        mem_port_arbiter_chk u_chk (
            .i_clk        (clk_i),
            .i_rst_n      (rst_ni),
            .i_state      (r_state),
            .i_instr_req  (instr_req_i),
            .i_data_req   (data_req_i),
            .i_rvalid     (mem_rvalid_i),
            .i_fifo_empty (w_fifo_empty)
        );
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus randomized traffic, all compared against a queue-based model of the arbiter.
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;
    localparam int MAXO = 2;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          instr_req_i = 1'b0;
    logic [AW-1:0] instr_addr_i = '0;
    logic          instr_gnt_o, instr_rvalid_o;
    logic [DW-1:0] instr_rdata_o;
    logic          data_req_i = 1'b0;
    logic          data_we_i = 1'b0;
    logic [BW-1:0] data_be_i = '0;
    logic [AW-1:0] data_addr_i = '0;
    logic [DW-1:0] data_wdata_i = '0;
    logic          data_gnt_o, data_rvalid_o;
    logic [DW-1:0] data_rdata_o;
    logic          mem_req_o, mem_we_o;
    logic [BW-1:0] mem_be_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_gnt_i = 1'b0;
    logic          mem_rvalid_i = 1'b0;
    logic [DW-1:0] mem_rdata_i = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .MAX_OUTSTANDING (MAXO),
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .ASSERT_EN       (1'b0)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .data_req_i     (data_req_i),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_addr_i    (data_addr_i),
        .data_wdata_i   (data_wdata_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_be_o       (mem_be_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: 0 = instr, 1 = data; hold = -1 when no source is waiting for a grant.
    int m_q[$];
    int m_last = 1;
    int m_hold = -1;
    int m_sel;
    bit m_req, m_full, m_rv;

    always @(negedge clk) begin
        if (!rst_ni) begin
            m_q.delete();
            m_last = 1;
            m_hold = -1;
        end
        m_full = (m_q.size() >= MAXO);
        if (m_hold >= 0)                     m_sel = m_hold;
        else if (instr_req_i && data_req_i)  m_sel = (m_last == 1) ? 0 : 1;
        else if (instr_req_i)                m_sel = 0;
        else                                 m_sel = 1;
        m_req = ((m_sel == 0) ? instr_req_i : data_req_i) && !m_full;
        chk("mem_req", {63'd0, mem_req_o}, {63'd0, m_req});
        chk("instr_gnt", {63'd0, instr_gnt_o}, {63'd0, mem_gnt_i && m_req && (m_sel == 0)});
        chk("data_gnt", {63'd0, data_gnt_o}, {63'd0, mem_gnt_i && m_req && (m_sel == 1)});
        if (m_req) begin
            if (m_sel == 0) begin
                chk("mem_addr", {32'd0, mem_addr_o}, {32'd0, instr_addr_i});
                chk("mem_we", {63'd0, mem_we_o}, 64'd0);
                chk("mem_be", {60'd0, mem_be_o}, 64'hF);
                chk("mem_wdata", {32'd0, mem_wdata_o}, 64'd0);
            end else begin
                chk("mem_addr", {32'd0, mem_addr_o}, {32'd0, data_addr_i});
                chk("mem_we", {63'd0, mem_we_o}, {63'd0, data_we_i});
                chk("mem_be", {60'd0, mem_be_o}, {60'd0, data_be_i});
                chk("mem_wdata", {32'd0, mem_wdata_o}, {32'd0, data_wdata_i});
            end
        end
        m_rv = mem_rvalid_i && (m_q.size() > 0);
        chk("instr_rvalid", {63'd0, instr_rvalid_o}, {63'd0, m_rv ? (m_q[0] == 0) : 1'b0});
        chk("data_rvalid", {63'd0, data_rvalid_o}, {63'd0, m_rv ? (m_q[0] == 1) : 1'b0});
        chk("instr_rdata", {32'd0, instr_rdata_o}, {32'd0, mem_rdata_i});
        chk("data_rdata", {32'd0, data_rdata_o}, {32'd0, mem_rdata_i});
        if (rst_ni) begin
            if (m_rv) void'(m_q.pop_front());
            if (m_req && mem_gnt_i) begin
                m_q.push_back(m_sel);
                m_last = m_sel;
            end
            m_hold = (m_req && !mem_gnt_i) ? m_sel : -1;
        end
    end

    int outst = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        instr_req_i = 1'b0; instr_addr_i = '0;
        data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = '0; data_addr_i = '0; data_wdata_i = '0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        clear_inputs();
        outst = 0;
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
    endtask

    bit pend_i, pend_d;

    initial begin
        do_reset();
        #2;
        chk("rst_mem_req", {63'd0, mem_req_o}, 64'd0);
        chk("rst_mem_be", {60'd0, mem_be_o}, 64'd0);
        chk("rst_mem_addr", {32'd0, mem_addr_o}, 64'd0);
        chk("rst_mem_we", {63'd0, mem_we_o}, 64'd0);
        chk("rst_mem_wdata", {32'd0, mem_wdata_o}, 64'd0);
        chk("rst_gnts", {62'd0, instr_gnt_o, data_gnt_o}, 64'd0);
        chk("rst_rvalids", {62'd0, instr_rvalid_o, data_rvalid_o}, 64'd0);
        chk("rst_rdata", {instr_rdata_o, data_rdata_o}, 64'd0);

        // single fetch
        tick();
        instr_req_i = 1'b1; instr_addr_i = 32'h100; mem_gnt_i = 1'b1;
        #2;
        chk("t1_gnt", {63'd0, instr_gnt_o}, 64'd1);
        chk("t1_addr", {32'd0, mem_addr_o}, 64'h100);
        chk("t1_we", {63'd0, mem_we_o}, 64'd0);
        chk("t1_be", {60'd0, mem_be_o}, 64'hF);
        tick();
        instr_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
        #2;
        chk("t1_irv", {63'd0, instr_rvalid_o}, 64'd1);
        chk("t1_irdata", {32'd0, instr_rdata_o}, 64'hDEADBEEF);
        chk("t1_drv", {63'd0, data_rvalid_o}, 64'd0);

        // alternating grants under continuous contention
        do_reset();
        instr_req_i = 1'b1; instr_addr_i = 32'h10;
        data_req_i = 1'b1; data_addr_i = 32'h20; mem_gnt_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            mem_rvalid_i = (k > 0);
            #2;
            chk("t2_ignt", {63'd0, instr_gnt_o}, {63'd0, (k % 2) == 0});
            chk("t2_dgnt", {63'd0, data_gnt_o}, {63'd0, (k % 2) == 1});
            chk("t2_irv", {63'd0, instr_rvalid_o}, {63'd0, (k > 0) && ((k - 1) % 2 == 0)});
        end
        tick();
        instr_req_i = 1'b0; data_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
        #2;
        chk("t2_last_drv", {63'd0, data_rvalid_o}, 64'd1);

        // selection held while the grant is pending
        do_reset();
        instr_req_i = 1'b1; instr_addr_i = 32'h200;
        #2;
        chk("t3_addr0", {32'd0, mem_addr_o}, 64'h200);
        chk("t3_ignt0", {63'd0, instr_gnt_o}, 64'd0);
        for (int c = 1; c < 3; c++) begin
            tick();
            data_req_i = 1'b1; data_addr_i = 32'h300;
            #2;
            chk("t3_addr_held", {32'd0, mem_addr_o}, 64'h200);
            chk("t3_dgnt0", {63'd0, data_gnt_o}, 64'd0);
        end
        tick();
        mem_gnt_i = 1'b1;
        #2;
        chk("t3_ignt3", {63'd0, instr_gnt_o}, 64'd1);
        chk("t3_dgnt3", {63'd0, data_gnt_o}, 64'd0);
        tick();
        instr_req_i = 1'b0;
        #2;
        chk("t3_dgnt4", {63'd0, data_gnt_o}, 64'd1);
        chk("t3_addr4", {32'd0, mem_addr_o}, 64'h300);

        // outstanding limit
        do_reset();
        instr_req_i = 1'b1; instr_addr_i = 32'h400; mem_gnt_i = 1'b1;
        #2;
        chk("t4_gnt0", {63'd0, instr_gnt_o}, 64'd1);
        tick();
        #2;
        chk("t4_gnt1", {63'd0, instr_gnt_o}, 64'd1);
        tick();
        #2;
        chk("t4_full_req", {63'd0, mem_req_o}, 64'd0);
        chk("t4_full_gnt", {63'd0, instr_gnt_o}, 64'd0);
        tick();
        mem_rvalid_i = 1'b1;
        #2;
        chk("t4_pop_req", {63'd0, mem_req_o}, 64'd0);
        chk("t4_pop_irv", {63'd0, instr_rvalid_o}, 64'd1);
        tick();
        mem_rvalid_i = 1'b0;
        #2;
        chk("t4_resume_req", {63'd0, mem_req_o}, 64'd1);

        // store behind an outstanding fetch
        do_reset();
        instr_req_i = 1'b1; instr_addr_i = 32'h500; mem_gnt_i = 1'b1;
        tick();
        instr_req_i = 1'b0;
        data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'b0011; data_addr_i = 32'h40; data_wdata_i = 32'h1234;
        #2;
        chk("t5_dgnt", {63'd0, data_gnt_o}, 64'd1);
        chk("t5_we", {63'd0, mem_we_o}, 64'd1);
        chk("t5_be", {60'd0, mem_be_o}, 64'h3);
        chk("t5_wdata", {32'd0, mem_wdata_o}, 64'h1234);
        tick();
        data_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
        #2;
        chk("t5_rv1_i", {63'd0, instr_rvalid_o}, 64'd1);
        chk("t5_rv1_d", {63'd0, data_rvalid_o}, 64'd0);
        tick();
        #2;
        chk("t5_rv2_i", {63'd0, instr_rvalid_o}, 64'd0);
        chk("t5_rv2_d", {63'd0, data_rvalid_o}, 64'd1);

        // reset with a transaction in flight
        do_reset();
        instr_req_i = 1'b1; instr_addr_i = 32'h600; mem_gnt_i = 1'b1;
        tick();
        clear_inputs();
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1; mem_rvalid_i = 1'b1;
        #2;
        chk("t6_stray_i", {63'd0, instr_rvalid_o}, 64'd0);
        chk("t6_stray_d", {63'd0, data_rvalid_o}, 64'd0);
        tick();
        mem_rvalid_i = 1'b0; instr_req_i = 1'b1; mem_gnt_i = 1'b1;
        #2;
        chk("t6_req", {63'd0, instr_gnt_o}, 64'd1);
        tick();
        instr_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
        #2;
        chk("t6_rv", {63'd0, instr_rvalid_o}, 64'd1);
        tick();
        #2;
        chk("t6_empty_rv", {62'd0, instr_rvalid_o, data_rvalid_o}, 64'd0);

        // randomized traffic
        do_reset();
        pend_i = 1'b0;
        pend_d = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            tick();
            if (!pend_i) begin
                instr_req_i  = ($urandom_range(0, 2) != 0);
                instr_addr_i = $urandom;
            end
            if (!pend_d) begin
                data_req_i   = ($urandom_range(0, 1) != 0);
                data_we_i    = $urandom_range(0, 1) != 0;
                data_be_i    = BW'($urandom);
                data_addr_i  = $urandom;
                data_wdata_i = $urandom;
            end
            mem_gnt_i    = ($urandom_range(0, 2) != 0);
            mem_rvalid_i = (outst > 0) && ($urandom_range(0, 1) != 0);
            mem_rdata_i  = $urandom;
            #3;
            pend_i = instr_req_i && !instr_gnt_o;
            pend_d = data_req_i && !data_gnt_o;
            outst  = outst + ((mem_req_o && mem_gnt_i) ? 1 : 0) - (mem_rvalid_i ? 1 : 0);
        end
        tick();
        clear_inputs();
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
